// File: rtl/rk8e_db_channel.sv
// rtl/rk8e_db_channel.sv - RK8-E data-break (DMA) channel; optional RK8E_DB_TIMEOUT_EN mem_ack watchdog
module rk8e_db_channel #(
  parameter int AW  = 15,
  parameter int DW  = 12,
  parameter int TMO = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          data_break,
  input  logic          to_disk,
  input  logic [AW-1:0] dmaAddr,
  input  logic [DW-1:0] dmaDOUT,
  input  logic          cpu_boundary,
  output logic          break_in_prog,
  output logic          db1,
  output logic [DW-1:0] dmaDIN,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rd,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          db_done,
  output logic          db_err
);

  typedef enum logic [2:0] {IDLE, WAIT, RD, WR, FIN} state_t;

  state_t        state_q, state_d;
  logic          armed_q, armed_d;
  logic          db1_d, done_d, bip_d, rd_d, wr_d;
  logic [DW-1:0] din_d, wdata_d;
  logic [AW-1:0] addr_d;
  logic          tmo_hit;

`ifdef RK8E_DB_TIMEOUT_EN
  localparam int TW = $clog2(TMO + 1);

  logic [TW-1:0] tmo_cnt;
  logic          in_mem;

  assign in_mem  = (state_q == RD) || (state_q == WR);
  assign tmo_hit = in_mem && !mem_ack && (tmo_cnt == TW'(TMO - 1));

  // Watchdog counter: idles at zero outside RD/WR so every memory cycle starts fresh
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      tmo_cnt <= '0;
    else if (clear || !in_mem)
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + 1'b1;
  end

  // Sticky timeout flag, cleared only by reset or clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      db_err <= 1'b0;
    else if (clear)
      db_err <= 1'b0;
    else if (tmo_hit)
      db_err <= 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
  assign db_err  = 1'b0;
`endif

  // State and registered outputs; clear behaves exactly like reset but synchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      armed_q       <= 1'b0;
      db1           <= 1'b0;
      db_done       <= 1'b0;
      break_in_prog <= 1'b0;
      mem_rd        <= 1'b0;
      mem_wr        <= 1'b0;
      dmaDIN        <= '0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
    end else if (clear) begin
      state_q       <= IDLE;
      armed_q       <= 1'b0;
      db1           <= 1'b0;
      db_done       <= 1'b0;
      break_in_prog <= 1'b0;
      mem_rd        <= 1'b0;
      mem_wr        <= 1'b0;
      dmaDIN        <= '0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
    end else begin
      state_q       <= state_d;
      armed_q       <= armed_d;
      db1           <= db1_d;
      db_done       <= done_d;
      break_in_prog <= bip_d;
      mem_rd        <= rd_d;
      mem_wr        <= wr_d;
      dmaDIN        <= din_d;
      mem_addr      <= addr_d;
      mem_wdata     <= wdata_d;
    end
  end

  // Next state and next register values; a request re-arms only after data_break is seen low
  always_comb begin
    state_d = state_q;
    armed_d = armed_q | ~data_break;
    db1_d   = 1'b0;
    done_d  = 1'b0;
    bip_d   = break_in_prog;
    rd_d    = mem_rd;
    wr_d    = mem_wr;
    din_d   = dmaDIN;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    case (state_q)
      IDLE: begin
        if (data_break && armed_q)
          state_d = WAIT;
      end
      WAIT: begin
        if (!data_break) begin
          state_d = IDLE;
        end else if (cpu_boundary) begin
          addr_d  = dmaAddr;
          wdata_d = dmaDOUT;
          db1_d   = 1'b1;
          bip_d   = 1'b1;
          armed_d = 1'b0;
          if (to_disk) begin
            state_d = RD;
            rd_d    = 1'b1;
          end else begin
            state_d = WR;
            wr_d    = 1'b1;
          end
        end
      end
      RD: begin
        if (mem_ack) begin
          din_d   = mem_rdata;
          rd_d    = 1'b0;
          state_d = FIN;
        end else if (tmo_hit) begin
          rd_d    = 1'b0;
          state_d = FIN;
        end
      end
      WR: begin
        if (mem_ack || tmo_hit) begin
          wr_d    = 1'b0;
          state_d = FIN;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        bip_d   = 1'b0;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        bip_d   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rk8e_db_channel.sv
// tb/tb_rk8e_db_channel.sv - directed self-checking bench for rk8e_db_channel
module tb_rk8e_db_channel;

  logic        clk = 1'b0;
  logic        reset, clear, data_break, to_disk, cpu_boundary, mem_ack;
  logic [14:0] dmaAddr;
  logic [11:0] dmaDOUT, mem_rdata;
  logic        break_in_prog, db1, mem_rd, mem_wr, db_done, db_err;
  logic [11:0] dmaDIN, mem_wdata;
  logic [14:0] mem_addr;

  int total = 0;
  int bad   = 0;

  rk8e_db_channel #(.AW(15), .DW(12), .TMO(64)) dut (
    .clk(clk), .reset(reset), .clear(clear), .data_break(data_break),
    .to_disk(to_disk), .dmaAddr(dmaAddr), .dmaDOUT(dmaDOUT),
    .cpu_boundary(cpu_boundary), .break_in_prog(break_in_prog), .db1(db1),
    .dmaDIN(dmaDIN), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .db_done(db_done), .db_err(db_err)
  );

  always #5 clk = ~clk;

  // advance one clock and sample 1 time unit after the rising edge
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; clear = 1'b0; data_break = 1'b0; to_disk = 1'b0;
    cpu_boundary = 1'b0; mem_ack = 1'b0; dmaAddr = '0; dmaDOUT = '0; mem_rdata = '0;
    tick; tick;
    total++;
    if ({break_in_prog, db1, dmaDIN, mem_addr, mem_wdata, mem_rd, mem_wr, db_done, db_err} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got bip=%b db1=%b din=%o addr=%o wd=%o rd=%b wr=%b done=%b err=%b, need all 0",
               break_in_prog, db1, dmaDIN, mem_addr, mem_wdata, mem_rd, mem_wr, db_done, db_err);
    end
    reset = 1'b1;
    tick;
  endtask

  task automatic test_mem_read;
    data_break = 1'b0; tick;
    to_disk = 1'b1; dmaAddr = 15'o12345; dmaDOUT = 12'o0; cpu_boundary = 1'b1; data_break = 1'b1;
    tick;
    total++;
    if (db1 !== 1'b0) begin bad++; $display("FAIL rd_db1_early: got %b need 0", db1); end
    tick;
    total++;
    if ({db1, break_in_prog, mem_rd, mem_wr} !== 4'b1110) begin
      bad++; $display("FAIL rd_grant: got db1/bip/rd/wr=%b need 1110", {db1, break_in_prog, mem_rd, mem_wr});
    end
    total++;
    if (mem_addr !== 15'o12345) begin bad++; $display("FAIL rd_addr: got %o need 12345", mem_addr); end
    mem_ack = 1'b1; mem_rdata = 12'o7070; data_break = 1'b0;
    tick;
    mem_ack = 1'b0; mem_rdata = 12'o0;
    total++;
    if ({mem_rd, db1, db_done, break_in_prog} !== 4'b0001) begin
      bad++; $display("FAIL rd_fin: got rd/db1/done/bip=%b need 0001", {mem_rd, db1, db_done, break_in_prog});
    end
    total++;
    if (dmaDIN !== 12'o7070) begin bad++; $display("FAIL rd_data: got %o need 7070", dmaDIN); end
    tick;
    total++;
    if ({db_done, break_in_prog} !== 2'b10) begin
      bad++; $display("FAIL rd_done: got done/bip=%b need 10", {db_done, break_in_prog});
    end
    tick;
    total++;
    if (db_done !== 1'b0) begin bad++; $display("FAIL rd_done_pulse: got %b need 0", db_done); end
  endtask

  task automatic test_mem_write;
    int wr_cycles = 0;
    int rd_seen   = 0;
    data_break = 1'b0; tick;
    to_disk = 1'b0; dmaAddr = 15'o00200; dmaDOUT = 12'o4321; cpu_boundary = 1'b1; data_break = 1'b1;
    tick; tick;
    total++;
    if ({db1, mem_wr, mem_rd} !== 3'b110) begin
      bad++; $display("FAIL wr_grant: got db1/wr/rd=%b need 110", {db1, mem_wr, mem_rd});
    end
    dmaAddr = 15'o77777; dmaDOUT = 12'o1111; to_disk = 1'b1; data_break = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (mem_wr === 1'b1) wr_cycles++;
      if (mem_rd !== 1'b0) rd_seen++;
      total++;
      if ({mem_addr, mem_wdata} !== {15'o00200, 12'o4321}) begin
        bad++; $display("FAIL wr_latched: got addr=%o wd=%o need 00200/4321", mem_addr, mem_wdata);
      end
      if (i == 2) mem_ack = 1'b1;
      tick;
    end
    mem_ack = 1'b0;
    total++;
    if (wr_cycles != 3 || mem_wr !== 1'b0) begin
      bad++; $display("FAIL wr_strobe_len: got %0d cycles, wr now %b, need 3 and 0", wr_cycles, mem_wr);
    end
    tick;
    if (mem_rd !== 1'b0) rd_seen++;
    total++;
    if (db_done !== 1'b1) begin bad++; $display("FAIL wr_done: got %b need 1", db_done); end
    total++;
    if (rd_seen != 0) begin bad++; $display("FAIL wr_no_rd: got %0d rd cycles need 0", rd_seen); end
    total++;
    if (dmaDIN !== 12'o7070) begin bad++; $display("FAIL wr_din_hold: got %o need 7070", dmaDIN); end
    tick;
  endtask

  task automatic test_arbitration;
    int early = 0;
    data_break = 1'b0; tick;
    cpu_boundary = 1'b0; to_disk = 1'b1; dmaAddr = 15'o00777; data_break = 1'b1;
    tick;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (db1 !== 1'b0 || break_in_prog !== 1'b0) early++;
    end
    total++;
    if (early != 0) begin bad++; $display("FAIL arb_hold: got %0d early grants need 0", early); end
    cpu_boundary = 1'b1;
    tick;
    total++;
    if ({db1, break_in_prog} !== 2'b11) begin
      bad++; $display("FAIL arb_grant: got db1/bip=%b need 11", {db1, break_in_prog});
    end
    mem_ack = 1'b1; mem_rdata = 12'o1234; data_break = 1'b0;
    tick;
    mem_ack = 1'b0;
    tick; tick;
    total++;
    if (dmaDIN !== 12'o1234) begin bad++; $display("FAIL arb_data: got %o need 1234", dmaDIN); end
  endtask

  task automatic test_wait_abort;
    int grants = 0;
    data_break = 1'b0; tick;
    cpu_boundary = 1'b0; data_break = 1'b1;
    tick;
    data_break = 1'b0;
    tick;
    cpu_boundary = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (db1 !== 1'b0 || break_in_prog !== 1'b0 || mem_rd !== 1'b0) grants++;
    end
    total++;
    if (grants != 0) begin bad++; $display("FAIL wait_abort: got %0d grant cycles need 0", grants); end
  endtask

  task automatic test_back_to_back;
    int n_db1 = 0;
    int n_done = 0;
    data_break = 1'b0; tick;
    to_disk = 1'b1; cpu_boundary = 1'b1; mem_rdata = 12'o0505; data_break = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick;
      if (db1 === 1'b1) n_db1++;
      if (db_done === 1'b1) n_done++;
      mem_ack = mem_rd | mem_wr;
    end
    total++;
    if (n_db1 != 1 || n_done != 1) begin
      bad++; $display("FAIL single_break: got db1=%0d done=%0d need 1/1", n_db1, n_done);
    end
    data_break = 1'b0; tick;
    data_break = 1'b1; n_done = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (db_done === 1'b1) n_done++;
      mem_ack = mem_rd | mem_wr;
    end
    mem_ack = 1'b0; data_break = 1'b0;
    total++;
    if (n_done != 1) begin bad++; $display("FAIL rearm_break: got done=%0d need 1", n_done); end
  endtask

  task automatic test_reset_mid;
    int late_done = 0;
    data_break = 1'b0; tick;
    to_disk = 1'b0; dmaAddr = 15'o00321; dmaDOUT = 12'o6543; cpu_boundary = 1'b1; data_break = 1'b1;
    tick; tick;
    data_break = 1'b0;
    tick;
    reset = 1'b0;
    #1;
    total++;
    if ({break_in_prog, db1, dmaDIN, mem_addr, mem_wdata, mem_rd, mem_wr, db_done, db_err} !== '0) begin
      bad++; $display("FAIL reset_mid: got bip=%b rd=%b wr=%b addr=%o wd=%o din=%o, need all 0",
                      break_in_prog, mem_rd, mem_wr, mem_addr, mem_wdata, dmaDIN);
    end
    tick;
    reset = 1'b1; mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (db_done !== 1'b0 || mem_wr !== 1'b0) late_done++;
    end
    mem_ack = 1'b0;
    total++;
    if (late_done != 0) begin bad++; $display("FAIL reset_late_ack: got %0d bad cycles need 0", late_done); end
  endtask

  task automatic test_clear_mid;
    int late_done = 0;
    data_break = 1'b0; tick;
    to_disk = 1'b1; dmaAddr = 15'o04000; cpu_boundary = 1'b1; data_break = 1'b1;
    tick; tick;
    data_break = 1'b0;
    total++;
    if (mem_rd !== 1'b1) begin bad++; $display("FAIL clear_setup: got rd=%b need 1", mem_rd); end
    clear = 1'b1;
    tick;
    clear = 1'b0;
    total++;
    if ({break_in_prog, db1, dmaDIN, mem_addr, mem_wdata, mem_rd, mem_wr, db_done, db_err} !== '0) begin
      bad++; $display("FAIL clear_mid: got bip=%b rd=%b addr=%o din=%o, need all 0",
                      break_in_prog, mem_rd, mem_addr, dmaDIN);
    end
    mem_ack = 1'b1; mem_rdata = 12'o3333;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (db_done !== 1'b0 || dmaDIN !== 12'o0) late_done++;
    end
    mem_ack = 1'b0;
    total++;
    if (late_done != 0) begin bad++; $display("FAIL clear_late_ack: got %0d bad cycles need 0", late_done); end
  endtask

`ifdef RK8E_DB_TIMEOUT_EN
  task automatic test_timeout;
    int strobe = 0;
    data_break = 1'b0; tick;
    to_disk = 1'b1; dmaAddr = 15'o01000; cpu_boundary = 1'b1; data_break = 1'b1;
    tick; tick;
    data_break = 1'b0;
    while (mem_rd === 1'b1 && strobe < 200) begin
      strobe++;
      tick;
    end
    total++;
    if (strobe != 64) begin bad++; $display("FAIL tmo_len: got %0d strobe cycles need 64", strobe); end
    total++;
    if ({db_err, db_done, dmaDIN} !== {1'b1, 1'b0, 12'o0}) begin
      bad++; $display("FAIL tmo_err: got err=%b done=%b din=%o need 1/0/0", db_err, db_done, dmaDIN);
    end
    tick;
    total++;
    if (db_done !== 1'b1) begin bad++; $display("FAIL tmo_done: got %b need 1", db_done); end
    tick; tick;
    total++;
    if (db_err !== 1'b1) begin bad++; $display("FAIL tmo_sticky: got %b need 1", db_err); end
    clear = 1'b1; tick; clear = 1'b0;
    total++;
    if (db_err !== 1'b0) begin bad++; $display("FAIL tmo_clear: got %b need 0", db_err); end
  endtask
`else
  task automatic test_no_timeout;
    data_break = 1'b0; tick;
    to_disk = 1'b1; dmaAddr = 15'o01000; cpu_boundary = 1'b1; data_break = 1'b1;
    tick; tick;
    data_break = 1'b0;
    for (int i = 0; i < 80; i++) tick;
    total++;
    if ({mem_rd, break_in_prog, db_err, db_done} !== 4'b1100) begin
      bad++; $display("FAIL no_timeout: got rd/bip/err/done=%b need 1100", {mem_rd, break_in_prog, db_err, db_done});
    end
    clear = 1'b1; tick; clear = 1'b0;
    total++;
    if (mem_rd !== 1'b0) begin bad++; $display("FAIL no_timeout_clear: got rd=%b need 0", mem_rd); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_mem_read;
    test_mem_write;
    test_arbitration;
    test_wait_abort;
    test_back_to_back;
    test_reset_mid;
    test_clear_mid;
`ifdef RK8E_DB_TIMEOUT_EN
    test_timeout;
`else
    test_no_timeout;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
